// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared FSM states, LBP bit positions and 3x3 window tap indices
package lbp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SLIDE,
        ST_WRITE,
        ST_BORDER,
        ST_DONE
    } state_t;

    localparam int BIT_NW = 0;
    localparam int BIT_N  = 1;
    localparam int BIT_NE = 2;
    localparam int BIT_W  = 3;
    localparam int BIT_E  = 4;
    localparam int BIT_SW = 5;
    localparam int BIT_S  = 6;
    localparam int BIT_SE = 7;

    // Taps are row-major: row 0 is the row above the centre.
    localparam int TAP_NW   = 0;
    localparam int TAP_N    = 1;
    localparam int TAP_NE   = 2;
    localparam int TAP_W    = 3;
    localparam int TAP_C    = 4;
    localparam int TAP_E    = 5;
    localparam int TAP_SW   = 6;
    localparam int TAP_S    = 7;
    localparam int TAP_SE   = 8;
    localparam int NUM_TAPS = 9;

    function automatic logic [3:0] tap_index(input logic [1:0] krow, input logic [1:0] kcol);
        return 4'(krow) * 4'd3 + 4'(kcol);
    endfunction

endpackage

// File: rtl/lbp_window.sv
// rtl/lbp_window.sv - 3x3 pixel window with left shift, single-tap load and LBP comparators
module lbp_window
    import lbp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_i,
    input  logic       load_i,
    input  logic [3:0] load_tap_i,
    input  logic [7:0] load_data_i,
    output logic [7:0] code_o
);

    logic [7:0] win_q [NUM_TAPS];

    // The right column keeps stale pixels after a shift; they are refetched before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            if (shift_i) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]   <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                end
            end
            if (load_i) begin
                win_q[load_tap_i] <= load_data_i;
            end
        end
    end

    always_comb begin
        code_o         = '0;
        code_o[BIT_NW] = win_q[TAP_NW] >= win_q[TAP_C];
        code_o[BIT_N]  = win_q[TAP_N]  >= win_q[TAP_C];
        code_o[BIT_NE] = win_q[TAP_NE] >= win_q[TAP_C];
        code_o[BIT_W]  = win_q[TAP_W]  >= win_q[TAP_C];
        code_o[BIT_E]  = win_q[TAP_E]  >= win_q[TAP_C];
        code_o[BIT_SW] = win_q[TAP_SW] >= win_q[TAP_C];
        code_o[BIT_S]  = win_q[TAP_S]  >= win_q[TAP_C];
        code_o[BIT_SE] = win_q[TAP_SE] >= win_q[TAP_C];
    end

endmodule

// File: rtl/lbp_slide.sv
// rtl/lbp_slide.sv - raster LBP engine with a sliding 3x3 window over a gray-image memory
// Optional macro LBP_BORDER_WRITE_EN: also writes zero codes for border pixels in raster order.
module lbp_slide
    import lbp_pkg::*;
#(
    parameter int IMG_W_LOG2 = 7,
    parameter int IMG_H_LOG2 = 7,
    parameter int ADDR_W     = IMG_W_LOG2 + IMG_H_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              gray_req,
    input  logic              gray_ready,
    input  logic [7:0]        gray_data,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_valid,
    output logic [7:0]        lbp_data,
    output logic              finish
);

`ifdef LBP_BORDER_WRITE_EN
    localparam logic [IMG_W_LOG2-1:0] COL_LAST = '1;
    localparam logic [IMG_H_LOG2-1:0] ROW_LAST = '1;
`else
    localparam logic [IMG_W_LOG2-1:0] COL_END = {{(IMG_W_LOG2-1){1'b1}}, 1'b0};
    localparam logic [IMG_H_LOG2-1:0] ROW_END = {{(IMG_H_LOG2-1){1'b1}}, 1'b0};
`endif

    state_t                  state_q;
    logic [IMG_H_LOG2-1:0]   row_q, row_d;
    logic [IMG_W_LOG2-1:0]   col_q, col_d;
    logic [1:0]              krow_q, krow_d;
    logic [1:0]              kcol_q, kcol_d;
    logic                    req_q;
    logic [ADDR_W-1:0]       gray_addr_q;
    logic                    pend_q;
    logic                    pend_last_q;
    logic [3:0]              pend_tap_q;
    logic                    lbp_valid_q;
    logic [ADDR_W-1:0]       lbp_addr_q;
    logic                    finish_q;
    logic                    accept;
    logic                    fetch_last;
    logic                    last_pix;
    logic                    next_fill;
    logic                    go_slide;
    logic [ADDR_W-1:0]       step_addr;
    logic [ADDR_W-1:0]       first_addr;
    logic [7:0]              code;
`ifdef LBP_BORDER_WRITE_EN
    logic                    next_border;
    logic                    border_q;
`endif

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [IMG_H_LOG2-1:0] r,
                                                   input logic [IMG_W_LOG2-1:0] c);
        return ADDR_W'({r, c});
    endfunction

    assign accept = req_q && gray_ready;

    // Fetch walk is column-major: krow advances fastest, FILL starts at column 0, SLIDE at 2.
    always_comb begin
        fetch_last = (krow_q == 2'd2) && (kcol_q == 2'd2);
        krow_d     = (krow_q == 2'd2) ? 2'd0 : krow_q + 2'd1;
        kcol_d     = (krow_q == 2'd2) ? kcol_q + 2'd1 : kcol_q;
        step_addr  = pix_addr(row_q - 1'b1 + IMG_H_LOG2'(krow_d),
                              col_q - 1'b1 + IMG_W_LOG2'(kcol_d));
    end

    always_comb begin
        row_d     = row_q;
        col_d     = col_q + 1'b1;
        next_fill = 1'b0;
`ifdef LBP_BORDER_WRITE_EN
        if (col_q == COL_LAST) begin
            row_d = row_q + 1'b1;
            col_d = '0;
        end
        last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);
        next_border = (row_d == '0) || (row_d == ROW_LAST) || (col_d == '0) || (col_d == COL_LAST);
        next_fill   = (col_d == IMG_W_LOG2'(1));
`else
        if (col_q == COL_END) begin
            row_d     = row_q + 1'b1;
            col_d     = IMG_W_LOG2'(1);
            next_fill = 1'b1;
        end
        last_pix = (row_q == ROW_END) && (col_q == COL_END);
`endif
        first_addr = pix_addr(row_d - 1'b1, next_fill ? col_d - 1'b1 : col_d + 1'b1);
    end

`ifdef LBP_BORDER_WRITE_EN
    assign go_slide = (state_q == ST_WRITE) && !last_pix && !next_border && !next_fill;
`else
    assign go_slide = (state_q == ST_WRITE) && !last_pix && !next_fill;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            krow_q      <= '0;
            kcol_q      <= '0;
            req_q       <= 1'b0;
            gray_addr_q <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_tap_q  <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            finish_q    <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
            border_q    <= 1'b0;
`endif
        end else begin
            // A response is captured the edge after its request was accepted, stall or not.
            pend_q <= accept;
            if (accept) begin
                pend_tap_q  <= tap_index(krow_q, kcol_q);
                pend_last_q <= fetch_last;
            end
            case (state_q)
                ST_IDLE: begin
`ifdef LBP_BORDER_WRITE_EN
                    state_q <= ST_BORDER;
`else
                    state_q     <= ST_FILL;
                    row_q       <= IMG_H_LOG2'(1);
                    col_q       <= IMG_W_LOG2'(1);
                    krow_q      <= '0;
                    kcol_q      <= '0;
                    req_q       <= 1'b1;
                    gray_addr_q <= '0;
`endif
                end
                ST_FILL, ST_SLIDE: begin
                    if (accept) begin
                        if (fetch_last) begin
                            req_q <= 1'b0;
                        end else begin
                            krow_q      <= krow_d;
                            kcol_q      <= kcol_d;
                            gray_addr_q <= step_addr;
                        end
                    end
                    if (pend_q && pend_last_q) begin
                        state_q     <= ST_WRITE;
                        lbp_valid_q <= 1'b1;
                        lbp_addr_q  <= pix_addr(row_q, col_q);
                    end
                end
                ST_WRITE: begin
                    lbp_valid_q <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
                    border_q    <= 1'b0;
`endif
                    if (last_pix) begin
                        state_q  <= ST_DONE;
                        finish_q <= 1'b1;
                    end
`ifdef LBP_BORDER_WRITE_EN
                    else if (next_border) begin
                        state_q <= ST_BORDER;
                        row_q   <= row_d;
                        col_q   <= col_d;
                    end
`endif
                    else begin
                        row_q       <= row_d;
                        col_q       <= col_d;
                        krow_q      <= '0;
                        req_q       <= 1'b1;
                        gray_addr_q <= first_addr;
                        if (next_fill) begin
                            state_q <= ST_FILL;
                            kcol_q  <= 2'd0;
                        end else begin
                            state_q <= ST_SLIDE;
                            kcol_q  <= 2'd2;
                        end
                    end
                end
`ifdef LBP_BORDER_WRITE_EN
                ST_BORDER: begin
                    state_q     <= ST_WRITE;
                    lbp_valid_q <= 1'b1;
                    lbp_addr_q  <= pix_addr(row_q, col_q);
                    border_q    <= 1'b1;
                end
`endif
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    lbp_window u_window (
        .clk         (clk),
        .reset       (reset),
        .shift_i     (go_slide),
        .load_i      (pend_q),
        .load_tap_i  (pend_tap_q),
        .load_data_i (gray_data),
        .code_o      (code)
    );

    assign gray_addr = gray_addr_q;
    assign gray_req  = req_q & gray_ready;
    assign lbp_addr  = lbp_addr_q;
    assign lbp_valid = lbp_valid_q;
    assign finish    = finish_q;
`ifdef LBP_BORDER_WRITE_EN
    assign lbp_data  = (lbp_valid_q && !border_q) ? code : 8'h00;
`else
    assign lbp_data  = lbp_valid_q ? code : 8'h00;
`endif

endmodule

// File: tb/tb_lbp_slide.sv
// tb/tb_lbp_slide.sv - randomized bench for lbp_slide against a raster-order LBP reference model
module tb_lbp_slide;

    localparam int WL = 4;
    localparam int HL = 3;
    localparam int W  = 1 << WL;
    localparam int H  = 1 << HL;
    localparam int N  = W * H;
    localparam int AW = WL + HL;
`ifdef LBP_BORDER_WRITE_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam int NWR        = BORDER ? N : (W - 2) * (H - 2);
    localparam int FIRST_ADDR = BORDER ? 0 : W + 1;
    localparam int BUDGET     = 20000;
    localparam int DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] gray_addr;
    logic          gray_req;
    logic          gray_ready = 1'b1;
    logic [7:0]    gray_data = 8'h00;
    logic [AW-1:0] lbp_addr;
    logic          lbp_valid;
    logic [7:0]    lbp_data;
    logic          finish;

    logic [7:0] mem [N];
    int         got_cnt [N];
    int         got_val [N];
    wr_t        exp_q [$];
    wr_t        mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ph = 0;
    int         rdy_mode = 0;
    int         wr_cnt = 0;
    int         last_cyc = 0;
    bit         speed_chk = 1'b0;
    logic       prev_valid = 1'b0;

    lbp_slide #(
        .IMG_W_LOG2 (WL),
        .IMG_H_LOG2 (HL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_addr  (gray_addr),
        .gray_req   (gray_req),
        .gray_ready (gray_ready),
        .gray_data  (gray_data),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_interior(input int r, input int c);
        return (r > 0) && (r < H - 1) && (c > 0) && (c < W - 1);
    endfunction

    function automatic int ref_code(input int r, input int c);
        int code = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem[(r + DR[i]) * W + c + DC[i]] >= mem[r * W + c]) code |= (1 << i);
        end
        return code;
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (is_interior(r, c)) exp_q.push_back('{addr: r * W + c, data: ref_code(r, c)});
                else if (BORDER) exp_q.push_back('{addr: r * W + c, data: 0});
            end
        end
    endtask

    task automatic randomize_image();
        for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gray_req && gray_ready) gray_data <= mem[gray_addr];
        else gray_data <= 8'($urandom);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (rdy_mode)
                0: gray_ready = 1'b1;
                1: gray_ready = ((ph / 3) % 2) == 0;
                default: gray_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (lbp_valid) begin
                check("pulse_width", prev_valid, 0);
                if (exp_q.size() > 0) mon_e = exp_q.pop_front();
                else mon_e = '{addr: -1, data: -1};
                check("wr_addr", lbp_addr, mon_e.addr);
                check("wr_data", lbp_data, mon_e.data);
                if (speed_chk && wr_cnt > 0)
                    check("gap", (cyc - last_cyc) <= (((mon_e.addr % W) == 1) ? 11 : 5), 1);
                got_cnt[lbp_addr]++;
                got_val[lbp_addr] = lbp_data;
                wr_cnt++;
                last_cyc = cyc;
            end
            if (!gray_ready) check("req_while_busy", gray_req, 0);
            if (finish) begin
                check("req_after_finish", gray_req, 0);
                check("valid_after_finish", lbp_valid, 0);
            end
            prev_valid = lbp_valid;
        end
    end

    task automatic start_run(input int mode);
        @(negedge clk);
        #1;
        reset     = 1'b1;
        rdy_mode  = mode;
        build_exp();
        for (int a = 0; a < N; a++) begin
            got_cnt[a] = 0;
            got_val[a] = -1;
        end
        wr_cnt    = 0;
        speed_chk = (mode == 0) && !BORDER;
        repeat (2) begin
            @(negedge clk);
            check("rst_valid", lbp_valid, 0);
            check("rst_req", gray_req, 0);
        end
        #1 reset = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int n = 0;
        int bad = 0;
        while (!finish && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finish"}, finish, 1);
        check({tag, "_writes"}, wr_cnt, NWR);
        check({tag, "_leftover"}, exp_q.size(), 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (got_cnt[r * W + c] != ((is_interior(r, c) || BORDER) ? 1 : 0)) bad++;
            end
        end
        check({tag, "_addr_cover"}, bad, 0);
        repeat (10) @(negedge clk);
        check({tag, "_sticky"}, finish, 1);
    endtask

    initial begin
        int n;
        int ff;
        randomize_image();
        repeat (3) @(negedge clk);
        check("rst_gray_req", gray_req, 0);
        check("rst_gray_addr", gray_addr, 0);
        check("rst_lbp_valid", lbp_valid, 0);
        check("rst_lbp_addr", lbp_addr, 0);
        check("rst_lbp_data", lbp_data, 0);
        check("rst_finish", finish, 0);

        start_run(0);
        finish_run("rand");

        for (int a = 0; a < N; a++) mem[a] = 8'd50;
        start_run(0);
        finish_run("flat");
        ff = 0;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                if (got_val[r * W + c] == 8'hFF) ff++;
        check("flat_all_ff", ff, (W - 2) * (H - 2));

        randomize_image();
        mem[1*W+1] = 8'd101; mem[1*W+2] = 8'd99;  mem[1*W+3] = 8'd0;
        mem[2*W+1] = 8'd0;   mem[2*W+2] = 8'd100; mem[2*W+3] = 8'd100;
        mem[3*W+1] = 8'd0;   mem[3*W+2] = 8'd0;   mem[3*W+3] = 8'd0;
        start_run(0);
        finish_run("pattern");
        check("pattern_code", got_val[2*W+2], 8'h11);

        randomize_image();
        start_run(1);
        finish_run("toggle");

        randomize_image();
        start_run(2);
        finish_run("rand_ready");

        randomize_image();
        start_run(0);
        n = 0;
        while (!(lbp_valid && (lbp_addr >> WL) == 5) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("reach_row5", lbp_addr >> WL, 5);
        repeat (2) @(negedge clk);
        start_run(0);
        n = 0;
        while (!lbp_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("restart_addr", lbp_addr, FIRST_ADDR);
        finish_run("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
